led_sequencer: RTL and testbench
================================

Name: led_sequencer

Overview:
- Parametrised successor to the board's fixed 3-LED chaser: N_LED outputs, programmable step period, four runtime-selectable patterns, PWM brightness and polarity control.
- Sits directly behind the on-board LED pins and is driven by top-level straps or a control register.
- Produces one step_tick pulse per pattern step, used by other blocks as a slow heartbeat.

Parameters:
- N_LED, 3, number of LED outputs (>=1).
- STEP_CYCLES, 6_000_000, clock cycles per pattern step (0.25 s at 24 MHz); must be >=2.
- BREATHE_CYCLES, 47_000, clock cycles per breathe level increment or decrement.
- PWM_BITS, 8, PWM counter and duty width.
- ACTIVE_LOW, 1, 1 means an LED is lit when its pin is driven to 0.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset; synchronous and active-high.
- mode  in  2  pattern select: 0 ROTATE, 1 BOUNCE, 2 BLINK, 3 BREATHE.
- dir  in  1  ROTATE direction: 0 moves toward MSB, 1 moves toward LSB.
- pause  in  1  freezes the step and breathe timers and the pattern; PWM keeps running.
- brightness  in  PWM_BITS  duty cycle for ROTATE, BOUNCE and BLINK.
- led  out  N_LED  LED pins, registered.
- step_tick  out  1  one-cycle pulse at each pattern step, registered.

Behaviour:
- Reset (sys_rst=1 at a rising edge) clears:
  - prescaler, breathe counter, PWM counter and breathe level to 0;
  - bounce direction to "up";
  - pattern to one-hot bit0;
  - mode_q to 0;
  - step_tick to 0;
  - led to all-off (all 1s if ACTIVE_LOW, else all 0s).
- Prescaler:
  - Counts 0..STEP_CYCLES-1 and wraps.
  - tick is asserted while count == STEP_CYCLES-1 and pause == 0, giving exactly one tick per STEP_CYCLES cycles.
  - step_tick is tick delayed by one register.
- Pause:
  - pause=1 holds the prescaler, breathe counter, pattern and breathe level.
  - No ticks occur during pause.
  - Deasserting pause resumes counting from the held value.
- Mode change:
  - mode is registered into mode_q every cycle.
  - When mode != mode_q, the next edge performs a restart: pattern reinitialised for the new mode, prescaler and breathe counter cleared, breathe level set to 0, bounce direction set to up.
  - A restart takes priority over a coincident tick.
- Initial patterns: ROTATE and BOUNCE start at one-hot bit0; BLINK starts all-ones; BREATHE uses all-ones.
- On tick, by mode:
  - ROTATE: rotate by one position in the direction given by dir. MSB wraps to bit0, or bit0 wraps to MSB.
  - BOUNCE: shift one position in the internal direction. On reaching bit N_LED-1 the direction flips to down; on reaching bit0 it flips to up. The end LED is lit for exactly one step. Sequence for N_LED=3: 001,010,100,010,001.
  - BLINK: pattern inverts (all-ones and all-zeros alternate).
  - BREATHE: pattern is unchanged.
  - N_LED=1: ROTATE and BOUNCE hold a constant pattern.
- Breathe level:
  - Only in BREATHE mode, a separate counter of BREATHE_CYCLES steps the level by 1.
  - The level ramps 0 up to 2^PWM_BITS-1, then down to 0, and repeats.
  - Each extreme is held for one step only; there is no saturation stall.
- PWM:
  - pwm_cnt is free-running 0..2^PWM_BITS-1, never paused.
  - duty is the breathe level in BREATHE mode, otherwise brightness.
  - pwm_on = (pwm_cnt < duty). duty=0 gives fully off; max duty gives 255/256 on (for PWM_BITS=8).
- Output:
  - lit = pattern AND pwm_on (replicated across N_LED bits).
  - led = ACTIVE_LOW ? ~lit : lit, registered.
  - One cycle of latency from pattern or PWM state to pin.
- Arithmetic: all counters are unsigned. Prescaler and breathe counter widths are clog2 of their limits. No overflow is possible because each counter wraps at its limit.

Decomposition:
- Shared package led_pkg holds:
  - mode encodings MODE_ROTATE=0, MODE_BOUNCE=1, MODE_BLINK=2, MODE_BREATHE=3;
  - the localparam width helper based on clog2.
- Sub-module led_pwm(PWM_BITS) holds the free-running counter and compare. Inputs are duty; the output is pwm_on. It is reused for other board indicators.
- Prescaler, pattern FSM and breathe ramp stay in led_sequencer.

Test Plan:
- Bench parameters: N_LED=3, STEP_CYCLES=4, BREATHE_CYCLES=2, PWM_BITS=2, ACTIVE_LOW=1.
- Reset, then ROTATE with dir=0 and brightness=3 -> led starts at 111; step_tick fires every 4 cycles; lit pattern runs 001→010→100→001; pin shows 0 on the lit bit for 3 of every 4 cycles.
- ROTATE with dir=1 -> lit pattern runs 001→100→010→001; toggling dir mid-run reverses direction at the next tick.
- BOUNCE -> lit sequence is 001,010,100,010,001,010; bit 2 is lit for exactly one step.
- BLINK with brightness=0 -> led stays 111 on every cycle while step_tick still pulses every 4 cycles.
- BREATHE -> duty runs 0,1,2,3,2,1,0,… with each level lasting 2 cycles; all three LEDs are identical on every cycle.
- Pause asserted for 10 cycles mid-step -> no step_tick and the pattern is held. A mode change from ROTATE to BLINK coincident with a tick -> the restart wins and the pattern is 111. Asserting sys_rst mid-step -> on the next edge led=111 and step_tick=0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared encodings and helpers for the LED sequencer and related board indicators.
package led_pkg;

  localparam logic [1:0] MODE_ROTATE  = 2'd0;
  localparam logic [1:0] MODE_BOUNCE  = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  typedef enum logic {
    BounceUp   = 1'b0,
    BounceDown = 1'b1
  } bounce_dir_e;

  // Counter width able to hold 0..limit-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter with a duty compare; on while the count is below duty.
module led_pwm #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                pwm_on_o
);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    pwm_on_o = (cnt_q < duty_i);
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: step prescaler, four patterns, breathe ramp, PWM dimming, pin polarity.
module led_sequencer
  import led_pkg::*;
#(
  parameter int unsigned N_LED          = 3,
  parameter int unsigned STEP_CYCLES    = 6_000_000,
  parameter int unsigned BREATHE_CYCLES = 47_000,
  parameter int unsigned PWM_BITS       = 8,
  parameter bit          ACTIVE_LOW     = 1'b1
) (
  input  logic                sys_clk_i,
  input  logic                sys_rst_i,
  input  logic [1:0]          mode_i,
  input  logic                dir_i,
  input  logic                pause_i,
  input  logic [PWM_BITS-1:0] brightness_i,
  output logic [N_LED-1:0]    led_o,
  output logic                step_tick_o
);

  localparam int unsigned PRESC_W   = cnt_width(STEP_CYCLES);
  localparam int unsigned BREATHE_W = cnt_width(BREATHE_CYCLES);

  localparam logic [PRESC_W-1:0]   PRESC_MAX   = PRESC_W'(STEP_CYCLES - 1);
  localparam logic [BREATHE_W-1:0] BREATHE_MAX = BREATHE_W'(BREATHE_CYCLES - 1);
  localparam logic [PWM_BITS-1:0]  LEVEL_MAX   = {PWM_BITS{1'b1}};
  localparam logic [N_LED-1:0]     ONE_HOT0    = N_LED'(1);
  localparam logic [N_LED-1:0]     LED_OFF     = {N_LED{ACTIVE_LOW}};

  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [BREATHE_W-1:0] bcnt_q, bcnt_d;
  logic [PWM_BITS-1:0]  level_q, level_d;
  logic                 breathe_up_q, breathe_up_d;
  bounce_dir_e          bounce_dir_q, bounce_dir_d;
  logic [N_LED-1:0]     pattern_q, pattern_d;
  logic [1:0]           mode_q;
  logic                 step_tick_q;
  logic [N_LED-1:0]     led_q, led_d;

  logic                 restart;
  logic                 tick;
  logic [N_LED-1:0]     bounce_next;
  logic [PWM_BITS-1:0]  duty;
  logic                 pwm_on;
  logic [N_LED-1:0]     lit;

  function automatic logic [N_LED-1:0] init_pattern(input logic [1:0] mode);
    return ((mode == MODE_BLINK) || (mode == MODE_BREATHE)) ? {N_LED{1'b1}} : ONE_HOT0;
  endfunction

  assign restart = (mode_i != mode_q);
  assign tick    = (presc_q == PRESC_MAX) && !pause_i;

  // State register.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      presc_q      <= '0;
      bcnt_q       <= '0;
      level_q      <= '0;
      breathe_up_q <= 1'b1;
      bounce_dir_q <= BounceUp;
      pattern_q    <= ONE_HOT0;
      mode_q       <= MODE_ROTATE;
      step_tick_q  <= 1'b0;
      led_q        <= LED_OFF;
    end else begin
      presc_q      <= presc_d;
      bcnt_q       <= bcnt_d;
      level_q      <= level_d;
      breathe_up_q <= breathe_up_d;
      bounce_dir_q <= bounce_dir_d;
      pattern_q    <= pattern_d;
      mode_q       <= mode_i;
      step_tick_q  <= tick;
      led_q        <= led_d;
    end
  end

  // Next-state logic: restart beats tick, pause freezes everything except PWM.
  always_comb begin
    presc_d      = presc_q;
    bcnt_d       = bcnt_q;
    level_d      = level_q;
    breathe_up_d = breathe_up_q;
    bounce_dir_d = bounce_dir_q;
    pattern_d    = pattern_q;
    bounce_next  = (bounce_dir_q == BounceUp) ? (pattern_q << 1) : (pattern_q >> 1);

    if (restart) begin
      presc_d      = '0;
      bcnt_d       = '0;
      level_d      = '0;
      breathe_up_d = 1'b1;
      bounce_dir_d = BounceUp;
      pattern_d    = init_pattern(mode_i);
    end else if (!pause_i) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;

      if (mode_q == MODE_BREATHE) begin
        if (bcnt_q == BREATHE_MAX) begin
          bcnt_d = '0;
          // Triangle ramp: each extreme is visited once, then the slope reverses.
          if (breathe_up_q) begin
            if (level_q == LEVEL_MAX) begin
              level_d      = level_q - 1'b1;
              breathe_up_d = 1'b0;
            end else begin
              level_d = level_q + 1'b1;
            end
          end else if (level_q == '0) begin
            level_d      = level_q + 1'b1;
            breathe_up_d = 1'b1;
          end else begin
            level_d = level_q - 1'b1;
          end
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end

      if (tick) begin
        unique case (mode_q)
          MODE_ROTATE: begin
            if (dir_i) begin
              pattern_d = (pattern_q >> 1) | (pattern_q << (N_LED - 1));
            end else begin
              pattern_d = (pattern_q << 1) | (pattern_q >> (N_LED - 1));
            end
          end
          MODE_BOUNCE: begin
            if (N_LED > 1) begin
              pattern_d = bounce_next;
              if (bounce_next[N_LED-1]) begin
                bounce_dir_d = BounceDown;
              end else if (bounce_next[0]) begin
                bounce_dir_d = BounceUp;
              end
            end
          end
          MODE_BLINK:   pattern_d = ~pattern_q;
          MODE_BREATHE: pattern_d = pattern_q;
        endcase
      end
    end
  end

  led_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk_i   (sys_clk_i),
    .rst_i   (sys_rst_i),
    .duty_i  (duty),
    .pwm_on_o(pwm_on)
  );

  // Output logic: dim the pattern and apply pin polarity.
  always_comb begin
    duty  = (mode_q == MODE_BREATHE) ? level_q : brightness_i;
    lit   = pattern_q & {N_LED{pwm_on}};
    led_d = ACTIVE_LOW ? ~lit : lit;
  end

  assign led_o       = led_q;
  assign step_tick_o = step_tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with small timing parameters and hand-computed pin traces.
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       dir;
  logic       pause;
  logic [1:0] bright;
  logic [2:0] led;
  logic       step_tick;

  int n_cmp = 0;
  int n_err = 0;

  led_sequencer #(
    .N_LED         (3),
    .STEP_CYCLES   (4),
    .BREATHE_CYCLES(2),
    .PWM_BITS      (2),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .sys_clk_i   (clk),
    .sys_rst_i   (rst),
    .mode_i      (mode),
    .dir_i       (dir),
    .pause_i     (pause),
    .brightness_i(bright),
    .led_o       (led),
    .step_tick_o (step_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] m, input logic d, input logic [1:0] b);
    mode   = m;
    dir    = d;
    pause  = 1'b0;
    bright = b;
    rst    = 1'b1;
    tick_clk();
    tick_clk();
    rst    = 1'b0;
  endtask

  // Cycle k of n: pins at leds[3*(n-k) +: 3], step_tick at sts[n-k] (first listed = cycle 1).
  task automatic run_seq(input string tag, input int n, input logic [95:0] leds,
                         input logic [31:0] sts);
    for (int k = 1; k <= n; k++) begin
      tick_clk();
      check_val($sformatf("%s led c%0d", tag, k), 32'(led), 32'(leds[3*(n-k) +: 3]));
      check_val($sformatf("%s tick c%0d", tag, k), 32'(step_tick), 32'(sts[n-k]));
    end
  endtask

  initial begin
    rst = 1'b1;
    do_reset(2'd0, 1'b0, 2'd3);
    check_val("reset led", 32'(led), 32'h7);
    check_val("reset tick", 32'(step_tick), 32'h0);

    // ROTATE toward MSB, full brightness: PWM is off one cycle in four.
    run_seq("rot0", 16,
            {3'b110, 3'b110, 3'b110, 3'b111, 3'b101, 3'b101, 3'b101, 3'b111,
             3'b011, 3'b011, 3'b011, 3'b111, 3'b110, 3'b110, 3'b110, 3'b111},
            32'(16'b0001_0001_0001_0001));

    // ROTATE toward LSB, then reverse direction mid-run.
    do_reset(2'd0, 1'b1, 2'd3);
    run_seq("rot1", 12,
            {3'b110, 3'b110, 3'b110, 3'b111, 3'b011, 3'b011, 3'b011, 3'b111,
             3'b101, 3'b101, 3'b101, 3'b111},
            32'(12'b0001_0001_0001));
    dir = 1'b0;
    run_seq("rotflip", 8,
            {3'b110, 3'b110, 3'b110, 3'b111, 3'b101, 3'b101, 3'b101, 3'b111},
            32'(8'b0001_0001));

    // BOUNCE: first edge after reset is a restart, so ticks land on cycles 5, 9, 13...
    do_reset(2'd1, 1'b0, 2'd3);
    run_seq("bounce", 22,
            {3'b110, 3'b110, 3'b110, 3'b111, 3'b110, 3'b101, 3'b101, 3'b111,
             3'b101, 3'b011, 3'b011, 3'b111, 3'b011, 3'b101, 3'b101, 3'b111,
             3'b101, 3'b110, 3'b110, 3'b111, 3'b110, 3'b101},
            32'(22'b0000_1000_1000_1000_1000_10));

    // BLINK at full brightness, then at zero brightness (pins stay dark).
    do_reset(2'd2, 1'b0, 2'd3);
    run_seq("blink3", 10,
            {3'b110, 3'b000, 3'b000, 3'b111, 3'b000, 3'b111, 3'b111, 3'b111,
             3'b111, 3'b000},
            32'(10'b0000_1000_10));
    do_reset(2'd2, 1'b0, 2'd0);
    run_seq("blink0", 13,
            {3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
             3'b111, 3'b111, 3'b111, 3'b111, 3'b111},
            32'(13'b0000_1000_1000_1));

    // BREATHE: levels 0,0,1,1,2,2,3,3,2,2,1,1,0,0,1,1,... against PWM count k mod 4.
    do_reset(2'd3, 1'b0, 2'd0);
    run_seq("breathe", 18,
            {3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 3'b111, 3'b111,
             3'b000, 3'b000, 3'b111, 3'b111, 3'b000, 3'b111, 3'b111, 3'b111,
             3'b000, 3'b000},
            32'(18'b0000_1000_1000_1000_10));

    // Pause for 10 cycles mid-step: no tick, pattern held, PWM keeps running.
    do_reset(2'd0, 1'b0, 2'd3);
    run_seq("prepause", 2, {3'b110, 3'b110}, 32'(2'b00));
    pause = 1'b1;
    run_seq("pause", 10,
            {3'b110, 3'b111, 3'b110, 3'b110, 3'b110, 3'b111, 3'b110, 3'b110,
             3'b110, 3'b111},
            32'(10'b0));
    pause = 1'b0;
    run_seq("resume", 5, {3'b110, 3'b110, 3'b101, 3'b111, 3'b101}, 32'(5'b01000));

    // ROTATE -> BLINK on the same edge as a tick: restart wins, pattern becomes 111.
    do_reset(2'd0, 1'b0, 2'd3);
    run_seq("premode", 3, {3'b110, 3'b110, 3'b110}, 32'(3'b000));
    mode = 2'd2;
    tick_clk();
    check_val("modechg led c4", 32'(led), 32'h7);
    run_seq("modechg", 5, {3'b000, 3'b000, 3'b000, 3'b111, 3'b111}, 32'(5'b00010));

    // Reset on the edge where a tick would otherwise occur.
    do_reset(2'd0, 1'b0, 2'd3);
    run_seq("prerst", 7,
            {3'b110, 3'b110, 3'b110, 3'b111, 3'b101, 3'b101, 3'b101},
            32'(7'b0001000));
    rst = 1'b1;
    tick_clk();
    check_val("midrst led", 32'(led), 32'h7);
    check_val("midrst tick", 32'(step_tick), 32'h0);
    rst = 1'b0;
    run_seq("postrst", 4, {3'b110, 3'b110, 3'b110, 3'b111}, 32'(4'b0001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
